// File: rtl/ppc_fetch_pkg.sv
// ppc_fetch_pkg: shared types and widths for the instruction fetch queue.
//   state_t : fetch FSM states (IDLE / FETCH / WAIT)
//   entry_t : one queue entry, {inst, pc}, big-endian bit numbering
package ppc_fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 64;
    localparam int unsigned ADDR_W = PC_W - 3;   // doubleword address width

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT
    } state_t;

    typedef struct packed {
        logic [0:INST_W-1] inst;
        logic [0:PC_W-1]   pc;
    } entry_t;

endpackage

// File: rtl/ppc_fetch_queue_if.sv
// ppc_fetch_queue_if: memory read port, redirect input and decode handshake.
//   master : the fetch queue (drives mem_rd_*, inst_*; receives data, redirect, ready)
//   slave  : memory / writeback / decode side
interface ppc_fetch_queue_if;
    import ppc_fetch_pkg::*;

    logic                mem_rd_en;
    logic [0:ADDR_W-1]   mem_rd_addr;
    logic [0:63]         mem_rd_data;
    logic                redirect;
    logic [0:PC_W-1]     redirect_pc;
    logic                inst_valid;
    logic [0:INST_W-1]   inst;
    logic [0:PC_W-1]     inst_pc;
    logic                inst_ready;

    modport master (
        output mem_rd_en, mem_rd_addr, inst_valid, inst, inst_pc,
        input  mem_rd_data, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, inst_valid, inst, inst_pc,
        output mem_rd_data, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/ppc_inst_fifo.sv
// ppc_inst_fifo: circular instruction buffer, 0/1/2-wide push, 1-wide pop.
//   clk, rst      : clock, async active-high reset
//   flush         : empties the buffer; overrides push and pop
//   pushCnt       : number of entries to push (0..2), pushA first
//   pushA, pushB  : entries to push
//   pop           : advance head (caller guarantees non-empty)
//   head          : entry at head (don't-care when empty)
//   count         : number of stored entries
module ppc_inst_fifo
    import ppc_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       pushCnt,
    input  entry_t           pushA,
    input  entry_t           pushB,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           slots [DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else if (flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            headPtr <= headPtr + PTR_W'(pop);
            tailPtr <= tailPtr + PTR_W'(pushCnt);
            count   <= count + CNT_W'(pushCnt) - CNT_W'(pop);
        end
    end

    // Storage needs no reset; count qualifies every slot.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (pushCnt != 2'd0) slots[tailPtr] <= pushA;
            if (pushCnt == 2'd2) slots[tailPtr + PTR_W'(1)] <= pushB;
        end
    end

    assign head = slots[headPtr];

endmodule

// File: rtl/ppc_fetch_queue.sv
// ppc_fetch_queue: fetches doublewords, splits them into 32-bit instructions
// by fetch-PC bit 61 and queues them for decode; redirect flushes and restarts.
//   clk, rst     : clock, async active-high reset
//   bus (master) : mem_rd_en/mem_rd_addr/mem_rd_data, redirect/redirect_pc,
//                  inst_valid/inst/inst_pc/inst_ready
//   stat_insts   : accepted pops          (only with PPC_FETCH_STATS_EN)
//   stat_stalls  : FETCH cycles lacking space (only with PPC_FETCH_STATS_EN)
module ppc_fetch_queue
    import ppc_fetch_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [0:PC_W-1]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    ppc_fetch_queue_if.master  bus
`ifdef PPC_FETCH_STATS_EN
    ,
    output logic [0:31]        stat_insts,
    output logic [0:31]        stat_stalls
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_t           state;
    state_t           stateNext;
    logic [0:PC_W-1]  fpc;
    logic [CNT_W-1:0] count;
    logic             hasSpace;
    logic             issue;
    logic             pop;
    logic [1:0]       pushCnt;
    entry_t           pushA;
    entry_t           pushB;
    entry_t           head;
    logic             unusedRedirLsbs;

    // A request is only issued when a full doubleword fits, so pushes never overflow.
    assign hasSpace = (32'(count) + 32'd2) <= 32'(DEPTH);
    assign pop      = bus.inst_valid & bus.inst_ready;

    // Misaligned fpc (bit 61 set) keeps only the second word of the doubleword.
    assign pushA = fpc[61] ? '{inst: bus.mem_rd_data[32:63], pc: fpc}
                           : '{inst: bus.mem_rd_data[0:31],  pc: fpc};
    assign pushB = '{inst: bus.mem_rd_data[32:63], pc: fpc + PC_W'(4)};

    assign unusedRedirLsbs = ^bus.redirect_pc[PC_W-2:PC_W-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next state, request and push decode
    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        pushCnt   = 2'd0;
        case (state)
            IDLE:  stateNext = FETCH;
            FETCH: begin
                if (hasSpace && !bus.redirect) begin
                    issue     = 1'b1;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                stateNext = FETCH;
                pushCnt   = fpc[61] ? 2'd1 : 2'd2;
            end
            default: stateNext = IDLE;
        endcase
        if (bus.redirect) stateNext = FETCH;
    end

    // Fetch PC: redirect wins over the sequential advance after a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc <= RESET_PC;
        end else if (bus.redirect) begin
            fpc <= {bus.redirect_pc[0:PC_W-3], 2'b00};
        end else if (state == WAIT) begin
            fpc <= {fpc[0:ADDR_W-1] + ADDR_W'(1), 3'b000};
        end
    end

    ppc_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.redirect),
        .pushCnt (pushCnt),
        .pushA   (pushA),
        .pushB   (pushB),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );

    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = fpc[0:ADDR_W-1];
    assign bus.inst_valid  = (count != '0);
    assign bus.inst        = head.inst;
    assign bus.inst_pc     = head.pc;

`ifdef PPC_FETCH_STATS_EN
    // Counters survive redirect; a pop in a redirect cycle is not accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_insts  <= '0;
            stat_stalls <= '0;
        end else begin
            if (pop && !bus.redirect)          stat_insts  <= stat_insts + 32'd1;
            if (state == FETCH && !hasSpace)   stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: doc/ppc_fetch_queue.md
# ppc_fetch_queue

Instruction fetch front end for the PowerPC core. Fetches 64-bit doublewords from the memory instruction read port, splits each into 32-bit instructions according to fetch-PC bit 61, and buffers them in a small queue. Decode consumes the queue through a valid/ready handshake. Writeback redirects the queue on any non-sequential next PC, such as a taken branch.

## Interface
- `DEPTH`, 4: queue entries (32-bit instructions); power of two, ≥2
- `RESET_PC`, 0: fetch PC loaded on reset
- `clk` in 1: clock, all state on posedge
- `rst` in 1: asynchronous, active-high reset
- `mem_rd_en` out 1: doubleword read request
- `mem_rd_addr` out [0:60]: doubleword address = `fpc[0:60]`
- `mem_rd_data` in [0:63]: read data, valid exactly one cycle after the request cycle
- `redirect` in 1: flush and restart fetch
- `redirect_pc` in [0:63]: new fetch PC; bits 62:63 ignored (forced 0)
- `inst_valid` out 1: queue head valid
- `inst` out [0:31]: head instruction
- `inst_pc` out [0:63]: address of head instruction
- `inst_ready` in 1: decode accepts head

## Operation
- Bit numbering is big-endian: bit 0 is the MSB.
- Registers:
  - `fpc` [0:63]: next fetch address
  - `count` [$clog2(DEPTH+1)]
  - head/tail pointers
  - `state`
- Each queue entry holds {inst, pc}.
- FSM states and transitions:
  - IDLE: reset state; goes unconditionally to FETCH.
  - FETCH: `mem_rd_en` = (DEPTH−count ≥ 2) & ~redirect, combinational from registered state. On a request, go to WAIT; otherwise stay in FETCH.
  - WAIT: sample `mem_rd_data`, then return to FETCH.
- Response handling in WAIT:
  - `fpc[61]`=0: push `data[0:31]` (pc=fpc), then `data[32:63]` (pc=fpc+4).
  - `fpc[61]`=1: push only `data[32:63]` (pc=fpc).
  - In both cases `fpc` ← {fpc[0:60]+1, 3'b000}. The 64-bit add wraps modulo 2^64.
- Pop: `inst_valid & inst_ready` advances the head.
  - Push and pop in the same cycle are both applied.
  - The issue rule guarantees no overflow.
- `inst_valid` = (count≠0). `inst` and `inst_pc` are driven combinationally from the head entry; when invalid they are don't-care.
- Redirect, sampled at posedge:
  - Clears the queue (count=0, pointers reset).
  - `fpc` ← {redirect_pc[0:61], 2'b00}; state ← FETCH.
  - A response arriving in the same cycle is discarded.
  - A pop in the same cycle is discarded (the redirect has priority).
  - Redirect while in IDLE behaves identically.
- Reset:
  - state=IDLE, count=0, pointers=0, fpc=RESET_PC.
  - Outputs: `mem_rd_en`=0, `inst_valid`=0.
  - `mem_rd_addr`=RESET_PC[0:60]; `inst`/`inst_pc` are don't-care.
  - Reset mid-request abandons the request; the late data is ignored.

## Timing
- Cycle 0 is the first posedge with `rst` low; the state enters FETCH at that edge.
- From reset release:
  - `mem_rd_en` is high in cycle 0→1.
  - Data is sampled at edge 2.
  - `inst_valid` is high from cycle 2 onward.
- Redirect at edge N:
  - `inst_valid` is low after N.
  - A request is issued in cycle N→N+1.
  - A valid instruction is available after edge N+2.
- Peak throughput is 2 instructions per 2 cycles with an aligned fpc and a continuously ready consumer.
- At most one request is outstanding.

## Configuration
- `PPC_FETCH_STATS_EN` defined:
  - Adds output `stat_insts` [0:31], the count of accepted pops.
  - Adds output `stat_stalls` [0:31], the count of FETCH cycles with no request for lack of space.
  - Both counters reset to 0, wrap at 2^32, and are not cleared by redirect.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

## Structure
- `ppc_fetch_pkg`: state enum (IDLE/FETCH/WAIT), `INST_W`=32, `PC_W`=64, and the entry struct {inst, pc}.
- Sub-module `ppc_inst_fifo`: circular buffer with 0/1/2-wide push and 1-wide pop, plus count output. `ppc_fetch_queue` owns the FSM, `fpc`, the redirect logic and the stats.

## Test plan
- Reset release with RESET_PC=0, memory word0 = 0x38600005_38800007 (two addi instructions), `inst_ready`=1 → inst 0x38600005 @pc 0 after edge 2, then 0x38800007 @pc 4.
- `redirect_pc`=0x104 (bit 61 set) → one request to addr 0x20 for the doubleword at 0x100; only the low half is pushed, with pc 0x104; next request goes to doubleword 0x108.
- `inst_ready`=0 for 10 cycles, DEPTH=4 → count saturates at 4; `mem_rd_en` stays 0 while space < 2 and no entry is lost; on release, all instructions appear in order.
- Redirect in the same cycle as a WAIT response and a pop → response discarded, queue empty; the next `inst_pc` equals the redirect target.
- `rst` asserted during WAIT → `inst_valid`=0 immediately; after release, fetch restarts at RESET_PC.
- Stats build: 6 pops and 3 no-space stalls → `stat_insts`=6, `stat_stalls`=3; a redirect leaves both unchanged.
